// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared widths and refill FSM encoding for the instruction cache
package icache_refill_pkg;

    localparam int unsigned PC_BITS_DEF    = 16;
    localparam int unsigned INSTR_BITS_DEF = 32;
    localparam int unsigned BYTE_OFF_BITS  = 2;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped tag/data storage with per-line valid bits
module icache_array
    import icache_refill_pkg::*;
#(
    parameter int unsigned INSTR_BITS = INSTR_BITS_DEF,
    parameter int unsigned LINES      = 16,
    parameter int unsigned WORDS      = 4,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_all,
    input  logic                     we,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic [$clog2(WORDS)-1:0] wr_word,
    input  logic [INSTR_BITS-1:0]    wr_data,
    input  logic                     tag_we,
    input  logic [TAG_BITS-1:0]      wr_tag,
    input  logic                     valid_set,
    input  logic [$clog2(LINES)-1:0] rd_index,
    input  logic [$clog2(WORDS)-1:0] rd_word,
    output logic [INSTR_BITS-1:0]    rd_data,
    output logic [TAG_BITS-1:0]      rd_tag,
    output logic                     rd_valid
);

    logic [INSTR_BITS-1:0] data_q [LINES*WORDS];
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [LINES-1:0]      valid_q;

    always_ff @(posedge clk_i) begin
        if (we) data_q[{wr_index, wr_word}] <= wr_data;
        if (tag_we) tag_q[wr_index] <= wr_tag;
    end

    // Flush wins over a simultaneous set so a line filled across a flush stays invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) valid_q <= '0;
        else if (clr_all) valid_q <= '0;
        else if (valid_set) valid_q[wr_index] <= 1'b1;
    end

    assign rd_data  = data_q[{rd_index, rd_word}];
    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/icache_refill.sv
// icache_refill: zero-latency direct-mapped icache lookup with blocking line refill
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int unsigned PC_BITS    = PC_BITS_DEF,
    parameter int unsigned INSTR_BITS = INSTR_BITS_DEF,
    parameter int unsigned LINES      = 16,
    parameter int unsigned WORDS      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [PC_BITS-1:0]    addr_i,
    input  logic                  flush_i,
    output logic [INSTR_BITS-1:0] instr_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [PC_BITS-1:0]    mem_addr_o,
    input  logic                  mem_valid_i,
    input  logic [INSTR_BITS-1:0] mem_rdata_i
);

    localparam int unsigned OFF_W   = $clog2(WORDS);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned IDX_LSB = BYTE_OFF_BITS + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = PC_BITS - TAG_LSB;

    state_t                state_q, state_d;
    logic [OFF_W-1:0]      beat_q;
    logic [PC_BITS-1:0]    base_q;
    logic                  flushed_q;
    logic [INSTR_BITS-1:0] rd_data;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid;
    logic                  hit, beat_fire, last_beat;
    logic                  unused_byte_bits;

    assign unused_byte_bits = ^addr_i[BYTE_OFF_BITS-1:0];
    assign hit       = state_q == IDLE && rd_valid && rd_tag == addr_i[PC_BITS-1:TAG_LSB];
    assign beat_fire = state_q == REFILL && mem_valid_i;
    assign last_beat = beat_fire && beat_q == OFF_W'(WORDS - 1);

    icache_array #(
        .INSTR_BITS(INSTR_BITS),
        .LINES     (LINES),
        .WORDS     (WORDS),
        .TAG_BITS  (TAG_W)
    ) u_array (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_all  (flush_i),
        .we       (beat_fire),
        .wr_index (base_q[TAG_LSB-1:IDX_LSB]),
        .wr_word  (beat_q),
        .wr_data  (mem_rdata_i),
        .tag_we   (last_beat),
        .wr_tag   (base_q[PC_BITS-1:TAG_LSB]),
        .valid_set(last_beat && !flush_i && !flushed_q),
        .rd_index (addr_i[TAG_LSB-1:IDX_LSB]),
        .rd_word  (addr_i[IDX_LSB-1:BYTE_OFF_BITS]),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (hit ? IDLE : REFILL) : (last_beat ? IDLE : REFILL);
    end

    always_comb begin
        stall_o    = !hit;
        instr_o    = hit ? rd_data : '0;
        mem_req_o  = state_q == REFILL;
        mem_addr_o = state_q == REFILL ? base_q : '0;
    end

    // flushed_q remembers a flush seen mid-refill so the in-flight line never becomes valid.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            beat_q    <= '0;
            base_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            if (state_q == IDLE && !hit) base_q <= {addr_i[PC_BITS-1:IDX_LSB], {IDX_LSB{1'b0}}};
            beat_q    <= last_beat ? '0 : (beat_fire ? beat_q + OFF_W'(1) : beat_q);
            flushed_q <= state_q == REFILL && !last_beat && (flushed_q || flush_i);
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: scoreboard bench with a line-level cache model and randomized traffic
module tb_icache_refill;

    typedef struct {
        logic        stall;
        logic [31:0] instr;
        logic        req;
        logic [15:0] maddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // Reference model: whole lines, a pending-line record and a queue of collected beats.
    bit          known = 1'b0;
    bit          m_valid [16];
    logic [7:0]  m_tag   [16];
    logic [31:0] m_data  [16][4];
    bit          refilling = 1'b0;
    bit          m_flushed = 1'b0;
    logic [15:0] pend = '0;
    logic [31:0] beats[$];

    icache_refill dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .addr_i     (addr),
        .flush_i    (flush),
        .instr_o    (instr),
        .stall_o    (stall),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_valid_i(mem_valid),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (stall !== e.stall || instr !== e.instr || mem_req !== e.req || mem_addr !== e.maddr) begin
                    errors++;
                    $display("FAIL outputs @%0t addr=%h: got stall=%b instr=%h req=%b maddr=%h, required stall=%b instr=%h req=%b maddr=%h",
                             $time, addr, stall, instr, mem_req, mem_addr, e.stall, e.instr, e.req, e.maddr);
                end
            end
        end
    end

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = {8'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
        return a;
    endfunction

    task automatic step(input logic rn, input logic [15:0] a, input logic fl, input logic mv, input logic [31:0] d);
        int   idx;
        int   w;
        int   pidx;
        bit   hit;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; addr = a; flush = fl; mem_valid = mv; mem_rdata = d;
        idx = int'(a[7:4]);
        w   = int'(a[3:2]);
        hit = !refilling && m_valid[idx] && m_tag[idx] == a[15:8];
        e.stall = !hit;
        e.instr = hit ? m_data[idx][w] : 32'h0;
        e.req   = refilling;
        e.maddr = refilling ? pend : 16'h0;
        if (known) sb.push_back(e);
        if (!rn) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            refilling = 1'b0;
            m_flushed = 1'b0;
            pend = '0;
            beats.delete();
            known = 1'b1;
        end else if (!refilling) begin
            if (fl) foreach (m_valid[i]) m_valid[i] = 1'b0;
            if (!hit) begin
                refilling = 1'b1;
                m_flushed = 1'b0;
                pend = a & 16'hFFF0;
                beats.delete();
            end
        end else begin
            if (fl) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_flushed = 1'b1;
            end
            if (mv) begin
                beats.push_back(d);
                if (beats.size() == 4) begin
                    pidx = int'(pend[7:4]);
                    for (int k = 0; k < 4; k++) m_data[pidx][k] = beats[k];
                    m_tag[pidx]   = pend[15:8];
                    m_valid[pidx] = !m_flushed;
                    refilling = 1'b0;
                end
            end
        end
    endtask

    // Miss cycle (with a stray beat that must be ignored) then four beats; optional gaps,
    // wandering addr_i, flush on a chosen beat, or reset in place of a chosen beat.
    task automatic feed(input logic [15:0] a, input logic [31:0] base_word, input int gap,
                        input int flush_at, input int rst_at, input bit wander);
        step(1'b1, a, 1'b0, 1'b1, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            if (k == rst_at) begin
                step(1'b0, a, 1'b0, 1'b1, base_word + 32'(k));
                return;
            end
            repeat (gap) step(1'b1, wander ? rand_addr() : a, 1'b0, 1'b0, $urandom);
            step(1'b1, wander ? rand_addr() : a, 1'(k == flush_at), 1'b1, base_word + 32'(k));
        end
    endtask

    initial begin
        repeat (2) step(1'b0, 16'h0010, 1'b0, 1'b0, '0);
        feed(16'h0010, 32'hA0, 0, -1, -1, 1'b0);
        step(1'b1, 16'h0010, 1'b0, 1'b0, '0);
        step(1'b1, 16'h001C, 1'b0, 1'b0, '0);
        step(1'b1, 16'h0014, 1'b0, 1'b1, 32'h1234);
        feed(16'h0110, 32'hB0, 0, -1, -1, 1'b0);
        step(1'b1, 16'h0110, 1'b0, 1'b0, '0);
        step(1'b1, 16'h0118, 1'b0, 1'b0, '0);
        feed(16'h0010, 32'hA0, 0, -1, -1, 1'b0);
        feed(16'h0220, 32'hC0, 3, -1, -1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 16'h0220 + 16'(4 * k), 1'b0, 1'b0, '0);
        feed(16'h0030, 32'hD0, 2, -1, -1, 1'b1);
        step(1'b1, 16'h003C, 1'b0, 1'b0, '0);
        step(1'b1, 16'h001C, 1'b1, 1'b0, '0);
        step(1'b1, 16'h001C, 1'b0, 1'b0, '0);
        feed(16'h0010, 32'hE0, 0, 1, -1, 1'b0);
        step(1'b1, 16'h0010, 1'b0, 1'b0, '0);
        feed(16'h0010, 32'hA0, 0, -1, -1, 1'b0);
        feed(16'h0040, 32'hF0, 1, -1, 2, 1'b0);
        step(1'b1, 16'h0040, 1'b0, 1'b1, 32'hF3);
        step(1'b1, 16'h0010, 1'b0, 1'b0, '0);
        repeat (1500) begin
            if (refilling)
                step(1'($urandom_range(0, 99) != 0), rand_addr(), 1'($urandom_range(0, 29) == 0),
                     1'($urandom_range(0, 1)), $urandom);
            else
                step(1'($urandom_range(0, 99) != 0), rand_addr(), 1'($urandom_range(0, 29) == 0),
                     1'($urandom_range(0, 3) == 0), $urandom);
        end
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
